text_ram_reader: RTL and testbench
==================================

// Module: text_ram_reader
// PURPOSE
//  Read-side controller for the text RAM (s_mem2) that textfsm fills.
//  On start, it fetches msg_len consecutive 24-bit words from base_addr, one word per read_ready strobe.
//  Each word goes to sub_sys_text as a one-cycle valid pulse, so text rides the same sample cadence as audio.
//  Owns the RAM read port (rden/address); textfsm keeps wren/data.
// PARAMETERS
//  ADDR_W      8   RAM address width; address wraps modulo 2**ADDR_W
//  DATA_W      24  RAM word width
//  RD_LATENCY  2   cycles from rden (sampled) to valid ram_q; legal range 1..3
// PORTS
//  clk         in   1       CLOCK_50 system clock
//  reset       in   1       synchronous, active-high
//  start       in   1       1-cycle pulse: begin message read; ignored while busy
//  base_addr   in   ADDR_W  first word address, sampled on accepted start
//  msg_len     in   ADDR_W+1 word count, sampled on accepted start (0..2**ADDR_W)
//  read_ready  in   1       codec sample strobe; paces fetches
//  rden        out  1       RAM read enable, 1-cycle pulse per fetch
//  rd_address  out  ADDR_W  RAM address, stable from rden until the next fetch
//  ram_q       in   DATA_W  RAM read data
//  text_out    out  DATA_W  registered word to sub_sys_text data_in; holds until next word
//  text_valid  out  1       1-cycle pulse when text_out updates
//  busy        out  1       high from accepted start until done
//  done        out  1       1-cycle pulse at end of message
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: all outputs 0 (text_out=0, rd_address=0); state=IDLE; counters=0.
//  Reset mid-message aborts at once: no done pulse, and no further rden.
//  FSM states are IDLE, ISSUE, WAIT, PRESENT and DONE.
//  IDLE    : busy=0. On start:
//            - msg_len==0: go to DONE.
//            - otherwise: latch addr=base_addr, remaining=msg_len, go to ISSUE.
//  ISSUE   : busy=1. Wait for read_ready==1. In that cycle:
//            - rden=1 and rd_address=addr, both registered and seen the next cycle.
//            - lat=RD_LATENCY; go to WAIT.
//  WAIT    : decrement lat. When lat reaches 0: text_out<=ram_q, go to PRESENT.
//            read_ready is ignored here (not queued).
//  PRESENT : text_valid=1 for exactly one cycle; addr<=addr+1 (wraps to 0); remaining<=remaining-1.
//            If remaining==1, go to DONE; otherwise go to ISSUE.
//  DONE    : done=1 for one cycle, busy=0; return to IDLE.
//  Latency: rden high to text_valid high = RD_LATENCY+1 cycles.
//  At most one fetch per read_ready strobe.
//  A read_ready high in the same cycle as the start-accept cycle is not used.
//  start in any state other than IDLE is dropped; start and done in the same cycle is also dropped.
//  Width rules: remaining is ADDR_W+1 bits, so msg_len=2**ADDR_W reads the whole RAM once.
//  Address arithmetic is unsigned, modulo 2**ADDR_W.
// CONFIGURATION
//  TEXT_RD_TERM_STOP_EN defined:
//   - In WAIT-exit, if ram_q[7:0]==8'h00 (NUL), the word is not presented; go straight to DONE.
//   - text_out keeps its previous value.
//  TEXT_RD_TERM_STOP_EN undefined: exactly msg_len words are always presented; NUL bytes pass through as data.
// TESTING
//  1. base=8'h10, len=3, RAM[10..12]=24'h41,42,43, read_ready every 8 cycles
//     -> 3 text_valid pulses, text_out 41,42,43 in order; done 1 cycle after the 3rd; busy falls with done.
//  2. base=8'hFE, len=4 -> rd_address sequence FE,FF,00,01; 4 text_valid pulses.
//  3. len=0 start -> no rden; done pulse 2 cycles after start; busy high 1 cycle.
//  4. start pulsed again while busy (len=2 active) -> ignored; exactly 2 words, one done.
//  5. reset asserted 1 cycle after the 2nd rden of a len=5 read
//     -> next cycle all outputs 0, no done; new start works normally.
//  6. TEXT_RD_TERM_STOP_EN set, RAM[0..3]=48,49,00,4A, base=0, len=4
//     -> 2 valid pulses (48,49), then done; text_out stays 24'h49.
//     Macro undefined -> 4 pulses, including 24'h00.

Source files
------------

// File: rtl/text_ram_reader.sv
// Read-side controller for the text RAM: fetches msg_len words from base_addr, one per read_ready strobe.
// Optional feature: define TEXT_RD_TERM_STOP_EN to end a message early on a word whose low byte is NUL.
module text_ram_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 24,
    parameter int RD_LATENCY = 2    // legal range 1..3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              read_ready,
    output logic              rden,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] text_out,
    output logic              text_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [1:0]        lat_q, lat_d;
    logic              rden_q, rden_d;
    logic [ADDR_W-1:0] rd_address_q, rd_address_d;
    logic [DATA_W-1:0] text_out_q, text_out_d;
    logic              text_valid_q, text_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic start_ok;
    logic lat_done;
    logic term_hit;

    // done_q is visible while the FSM already sits in IDLE; a start in that cycle is dropped.
    assign start_ok = start && !done_q;
    // lat_q == 1 means this cycle's decrement reaches zero: ram_q is valid now.
    assign lat_done = (lat_q == 2'd1);

`ifdef TEXT_RD_TERM_STOP_EN
    assign term_hit = (ram_q[7:0] == 8'h00);
`else
    assign term_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values together.
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (msg_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (read_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_done) begin
                    state_d = term_hit ? S_DONE : S_PRESENT;
                end
            end
            S_PRESENT: begin
                state_d = (remaining_q == (ADDR_W+1)'(1)) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath logic: next values for the registered outputs and counters.
    always_comb begin
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        lat_d        = lat_q;
        rden_d       = 1'b0;
        rd_address_d = rd_address_q;
        text_out_d   = text_out_q;
        text_valid_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    busy_d      = 1'b1;
                    addr_d      = base_addr;
                    remaining_d = msg_len;
                end
            end
            S_ISSUE: begin
                if (read_ready) begin
                    rden_d       = 1'b1;
                    rd_address_d = addr_q;
                    lat_d        = LAT_INIT;
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 2'd1;
                if (lat_done && !term_hit) begin
                    text_out_d = ram_q;
                end
            end
            S_PRESENT: begin
                text_valid_d = 1'b1;
                addr_d       = addr_q + ADDR_W'(1);
                remaining_d  = remaining_q - (ADDR_W+1)'(1);
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any message with no done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            lat_q        <= '0;
            rden_q       <= 1'b0;
            rd_address_q <= '0;
            text_out_q   <= '0;
            text_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            lat_q        <= lat_d;
            rden_q       <= rden_d;
            rd_address_q <= rd_address_d;
            text_out_q   <= text_out_d;
            text_valid_q <= text_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rden       = rden_q;
    assign rd_address = rd_address_q;
    assign text_out   = text_out_q;
    assign text_valid = text_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_text_ram_reader.sv
// Bench for text_ram_reader: directed and randomized messages checked against a word-list model.
// Honours TEXT_RD_TERM_STOP_EN so the same bench covers both builds.
module tb_text_ram_reader;

    localparam int RD_LAT = 2;
`ifdef TEXT_RD_TERM_STOP_EN
    localparam bit TERM_STOP = 1'b1;
`else
    localparam bit TERM_STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  msg_len = '0;
    logic        read_ready = 1'b0;
    logic        rden;
    logic [7:0]  rd_address;
    logic [23:0] ram_q = '0;
    logic [23:0] text_out;
    logic        text_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // RAM model: one registered read stage, so data captured RD_LAT edges after rden rises.
    logic [23:0] mem [0:255];

    // Monitor records.
    logic [7:0]  rden_addr_q [$];
    int          rden_cyc_q  [$];
    logic [23:0] word_q      [$];
    int          tv_cyc_q    [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_cnt = 0;
    int          busy_at_done = 0;
    int          bad_fetch = 0;
    logic        rr_prev = 1'b0;

    // read_ready strobe generator controls.
    bit rr_en = 1'b0;
    int rr_period = 8;
    int rr_cnt = 0;

    text_ram_reader #(
        .ADDR_W    (8),
        .DATA_W    (24),
        .RD_LATENCY(RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .msg_len   (msg_len),
        .read_ready(read_ready),
        .rden      (rden),
        .rd_address(rd_address),
        .ram_q     (ram_q),
        .text_out  (text_out),
        .text_valid(text_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rden === 1'b1) ram_q <= mem[rd_address];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_en) begin
                if (rr_cnt >= rr_period - 1) begin
                    read_ready = 1'b1;
                    rr_cnt = 0;
                end else begin
                    read_ready = 1'b0;
                    rr_cnt++;
                end
            end else begin
                read_ready = 1'b0;
                rr_cnt = 0;
            end
        end
    end

    // Monitor samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rden === 1'b1) begin
                rden_addr_q.push_back(rd_address);
                rden_cyc_q.push_back(cyc);
                if (rr_prev !== 1'b1) bad_fetch++;
            end
            if (text_valid === 1'b1) begin
                word_q.push_back(text_out);
                tv_cyc_q.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy !== 1'b0) busy_at_done++;
            end
            if (busy === 1'b1) busy_cnt++;
            rr_prev = read_ready;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rden_addr_q.delete();
        rden_cyc_q.delete();
        word_q.delete();
        tv_cyc_q.delete();
        done_cnt = 0;
        done_cyc = 0;
        busy_cnt = 0;
        busy_at_done = 0;
        bad_fetch = 0;
    endtask

    function automatic logic [23:0] rand_word(input bit allow_nul);
        logic [23:0] w;
        w = {16'($urandom), 8'($urandom_range(1, 255))};
        if (allow_nul && $urandom_range(0, 3) == 0) w[7:0] = 8'h00;
        return w;
    endfunction

    task automatic check_outputs_zero(input string name);
        check({name, ":rden"}, rden, 0);
        check({name, ":rd_address"}, rd_address, 0);
        check({name, ":text_out"}, text_out, 0);
        check({name, ":text_valid"}, text_valid, 0);
        check({name, ":busy"}, busy, 0);
        check({name, ":done"}, done, 0);
    endtask

    // Runs one message and compares against the expected word/address lists.
    task automatic run_msg(input string name, input logic [7:0] base, input logic [8:0] len,
                           input int period, input int restart_at);
        logic [23:0] exp_words [$];
        logic [7:0]  exp_addr  [$];
        logic [7:0]  a;
        bit          stopped;
        int          budget;
        stopped = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 8'(i);
            exp_addr.push_back(a);
            if (TERM_STOP && mem[a][7:0] == 8'h00) begin
                stopped = 1'b1;
                break;
            end
            exp_words.push_back(mem[a]);
        end

        clear_mon();
        rr_period = period;
        rr_en = 1'b1;
        base_addr = base;
        msg_len = len;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        budget = (int'(len) + 2) * (period + 8) + 20;
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            if (k == restart_at) begin
                base_addr = base ^ 8'h5A;
                msg_len = 9'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick(1);
        end
        start = 1'b0;
        tick(4);
        rr_en = 1'b0;

        check({name, ":done_count"}, done_cnt, 1);
        check({name, ":word_count"}, word_q.size(), exp_words.size());
        check({name, ":fetch_count"}, rden_addr_q.size(), exp_addr.size());
        for (int i = 0; i < exp_words.size(); i++) begin
            if (i < word_q.size()) begin
                check($sformatf("%s:word%0d", name, i), word_q[i], exp_words[i]);
                check($sformatf("%s:latency%0d", name, i), tv_cyc_q[i] - rden_cyc_q[i], RD_LAT + 1);
            end
        end
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < rden_addr_q.size())
                check($sformatf("%s:addr%0d", name, i), rden_addr_q[i], exp_addr[i]);
        end
        check({name, ":fetch_without_strobe"}, bad_fetch, 0);
        check({name, ":busy_with_done"}, busy_at_done, 0);
        if (stopped && rden_cyc_q.size() > 0)
            check({name, ":done_after_nul"}, done_cyc - rden_cyc_q[rden_cyc_q.size()-1], RD_LAT + 1);
        else if (tv_cyc_q.size() > 0)
            check({name, ":done_after_last"}, done_cyc - tv_cyc_q[tv_cyc_q.size()-1], 1);
        if (exp_words.size() > 0)
            check({name, ":text_out_hold"}, text_out, exp_words[exp_words.size()-1]);
    endtask

    initial begin
        int          c0;
        logic [7:0]  base;
        logic [8:0]  len;

        for (int i = 0; i < 256; i++) mem[i] = rand_word(1'b0);

        // Reset state.
        reset = 1'b1;
        tick(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        tick(2);

        // Three words, strobe every 8 cycles.
        mem[8'h10] = 24'h000041;
        mem[8'h11] = 24'h000042;
        mem[8'h12] = 24'h000043;
        run_msg("basic", 8'h10, 9'd3, 8, -1);

        // Address wrap at the top of the RAM.
        run_msg("wrap", 8'hFE, 9'd4, 7, -1);

        // Zero-length message, then a start coinciding with done.
        clear_mon();
        c0 = cyc;
        msg_len = 9'd0;
        base_addr = 8'h33;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("len0:busy_after_start", busy, 1);
        tick(1);
        check("len0:done_pulse", done, 1);
        check("len0:busy_with_done", busy, 0);
        msg_len = 9'd3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        rr_en = 1'b1;
        tick(12);
        rr_en = 1'b0;
        check("len0:done_count", done_cnt, 1);
        check("len0:done_delay", done_cyc - c0, 2);
        check("len0:busy_cycles", busy_cnt, 1);
        check("len0:no_fetch", rden_addr_q.size(), 0);

        // Start while busy is dropped.
        base = 8'($urandom);
        run_msg("restart_ignored", base, 9'd2, 8, 3);

        // Reset one cycle after the second fetch of a five-word message.
        base = 8'($urandom);
        for (int i = 0; i < 5; i++) mem[base + 8'(i)] = rand_word(1'b0);
        clear_mon();
        rr_period = 6;
        rr_en = 1'b1;
        base_addr = base;
        msg_len = 9'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int k = 0; k < 200 && rden_addr_q.size() < 2; k++) @(negedge clk);
        check("rst:second_fetch_seen", rden_addr_q.size(), 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1);
        check_outputs_zero("rst_mid");
        reset = 1'b0;
        tick(15);
        rr_en = 1'b0;
        check("rst:no_more_fetch", rden_addr_q.size(), 2);
        check("rst:no_done", done_cnt, 0);
        run_msg("rst_restart", base, 9'd3, 6, -1);

        // NUL word handling: stops early only when TEXT_RD_TERM_STOP_EN is defined.
        mem[0] = 24'h000048;
        mem[1] = 24'h000049;
        mem[2] = 24'h000000;
        mem[3] = 24'h00004A;
        run_msg("nul", 8'h00, 9'd4, 8, -1);
        check("nul:final_text_out", text_out, TERM_STOP ? 24'h000049 : 24'h00004A);

        // Randomized messages.
        for (int r = 0; r < 6; r++) begin
            base = 8'($urandom);
            len = 9'($urandom_range(1, 7));
            for (int i = 0; i < int'(len); i++) mem[base + 8'(i)] = rand_word(1'b1);
            run_msg($sformatf("rand%0d", r), base, len, $urandom_range(4, 12), -1);
        end

        // Whole RAM in one message.
        for (int i = 0; i < 256; i++) mem[i] = rand_word(1'b0);
        run_msg("full_ram", 8'($urandom), 9'd256, 5, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
